sram_emu: RTL and testbench
===========================

# sram_emu

Synthesizable responder for the external asynchronous SRAM bus (20-bit address, 32-bit bidirectional data, active-low CS/OE/WE). It sits on the far side of the SRAM pins and stands in for the physical chip in simulation and in on-FPGA loopback builds. It stores words in internal block RAM and answers reads after a programmable latency, so the SRAM-side controller can be exercised against a known-good model with realistic access timing.

## Interface
- ADDR_W, 10: implemented address bits (depth = 2^ADDR_W words).
- READ_LAT, 2: cycles from read-condition sample to data drive; legal range 1..15.
- clk  in  1  clock; all bus pins sampled on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- addr  in  20  word address from the controller.
- data  inout  32  driven by this block only in RD_DRIVE, else 32'bz.
- CS  in  1  chip select, active-low.
- OE  in  1  output enable, active-low.
- WE  in  1  write enable, active-low; dominates OE.
- busy  out  1  high in any state other than IDLE.
- viol  out  1  sticky protocol/range violation flag, cleared only by reset.

## Operation
- States: IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE; 4-bit latency counter lat_cnt.
- Read condition: CS=0, OE=0, WE=1. Write condition: CS=0, WE=0 (OE ignored; OE=0 with WE=0 is a legal write, no drive).
- IDLE: write condition -> WR_ACTIVE, latch addr into wa, data into wd. Else read condition -> RD_WAIT, lat_cnt=1, latch addr into ra. Else stay.
- RD_WAIT: read condition lost -> IDLE. addr != ra -> stay, ra=addr, lat_cnt=1. Else lat_cnt==READ_LAT -> RD_DRIVE, load rdata=mem[ra]; else lat_cnt+1. Write condition -> IDLE first (write starts on the following edge).
- RD_DRIVE: output enable = (state==RD_DRIVE) & !CS & !OE & WE, combinational, so bus releases same cycle the controller lifts CS/OE or lowers WE. Read condition lost -> IDLE. addr change -> RD_WAIT, ra=addr, lat_cnt=1 (data tri-states).
- WR_ACTIVE: each edge with write condition still true: wd=data (last sample wins); addr != wa -> viol=1, wa unchanged. Edge where WE=1 or CS=1: commit mem[wa]=wd, go IDLE.
- Range: addr[19:ADDR_W] nonzero -> writes not committed, reads drive 32'h0000_0000, viol=1.
- Memory contents undefined at power-up; not cleared by reset.

## Timing
- Reset: state=IDLE, lat_cnt=0, busy=0, viol=0, data=z; pending write in WR_ACTIVE discarded (memory unmodified).
- Read latency: condition first sampled at edge k -> data valid after edge k+READ_LAT, held until condition drops.
- Write commit: at edge where WE (or CS) first sampled high; readable by a read condition sampled on the next edge.
- Back-to-back: write end -> IDLE one cycle; read end -> IDLE one cycle; no direct WR_ACTIVE<->RD transitions.
- lat_cnt never exceeds READ_LAT; no wrap.

## Test plan
- Write 32'hCAFE_0001 to addr 5 (CS=0, WE=0 for 3 cycles, OE=1), release; read addr 5 with READ_LAT=2 -> data z after edges 1, 32'hCAFE_0001 exactly after edge 2, busy=1 throughout, viol=0.
- Write with OE=0 and WE=0 together, data changing 0x11->0x22->0x33 per cycle -> data pin never driven; later read returns 0x33.
- Read addr 5 in RD_DRIVE, switch addr to 6 (holding 0xABCD) -> data z at once, 0xABCD after 2 more edges.
- Assert rst mid WR_ACTIVE on addr 7 (previous 0x77) -> state IDLE, busy=0; read addr 7 returns 0x77.
- Write to addr 20'h0_0800 with ADDR_W=10 -> viol=1, no aliasing: addr 0 keeps its value; read of 20'h0_0800 returns 0.
- Change addr during write condition -> viol=1, data committed to entry address only.

Source files
------------

// File: rtl/sram_emu.sv
// sram_emu: stand-in for an external asynchronous SRAM chip.
// Sits on the pin side of the SRAM bus, stores words in internal block RAM
// and answers reads after READ_LAT cycles. Every bus pin is sampled on the
// rising clock edge. The data pins are driven only while a read is being
// presented. viol latches any out-of-range access or any address change
// during a write, and stays set until reset.
module sram_emu #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] addr,
  inout  wire  [31:0] data,
  input  logic        CS,
  input  logic        OE,
  input  logic        WE,
  output logic        busy,
  output logic        viol
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT   = 4'(READ_LAT);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE} state_t;

  state_t      state;
  logic [3:0]  lat_cnt;
  logic [19:0] ra;
  logic [19:0] wa;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic [31:0] mem [DEPTH];

  logic rd_cond;
  logic wr_cond;
  logic addr_ok;
  logic ra_ok;
  logic wa_ok;
  logic rd_load;
  logic mem_we;
  logic drive_en;

  // WE low dominates, so a read needs WE high on top of CS and OE low.
  assign rd_cond  = ~CS & ~OE & WE;
  assign wr_cond  = ~CS & ~WE;
  assign addr_ok  = (addr[19:ADDR_W] == '0);
  assign ra_ok    = (ra[19:ADDR_W] == '0);
  assign wa_ok    = (wa[19:ADDR_W] == '0);
  assign rd_load  = (state == RD_WAIT) && rd_cond && (addr == ra) && (lat_cnt == LAT);
  assign mem_we   = (state == WR_ACTIVE) && !wr_cond && wa_ok;
  assign drive_en = (state == RD_DRIVE) && rd_cond;

  // Release the bus in the same cycle the controller drops the read.
  assign data = drive_en ? rdata : 'z;

  // Bus protocol FSM; busy and viol are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
      ra      <= '0;
      wa      <= '0;
      wd      <= '0;
      busy    <= 1'b0;
      viol    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_cond) begin
            state <= WR_ACTIVE;
            busy  <= 1'b1;
            wa    <= addr;
            wd    <= data;
            if (!addr_ok) viol <= 1'b1;
          end else if (rd_cond) begin
            state   <= RD_WAIT;
            busy    <= 1'b1;
            lat_cnt <= 4'd1;
            ra      <= addr;
            if (!addr_ok) viol <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (!rd_cond) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (addr != ra) begin
            ra      <= addr;
            lat_cnt <= 4'd1;
            if (!addr_ok) viol <= 1'b1;
          end else if (lat_cnt == LAT) begin
            state <= RD_DRIVE;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RD_DRIVE: begin
          if (!rd_cond) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (addr != ra) begin
            state   <= RD_WAIT;
            ra      <= addr;
            lat_cnt <= 4'd1;
            if (!addr_ok) viol <= 1'b1;
          end
        end
        WR_ACTIVE: begin
          if (wr_cond) begin
            wd <= data;
            if (addr != wa) viol <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: no reset, so a write still pending at reset is simply dropped.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wa[ADDR_W-1:0]] <= wd;
    if (rd_load) rdata <= ra_ok ? mem[ra[ADDR_W-1:0]] : 32'h0000_0000;
  end

endmodule

// File: tb/tb_sram_emu.sv
// tb_sram_emu: transaction-level stimulus with a per-cycle scoreboard.
// Each driven cycle pushes the expected busy/viol/bus values, worked out
// from the read/write rules of the SRAM bus. A negedge monitor pops and
// compares them. Undriven data bits are pulled up, so a released bus reads
// as all ones.
`timescale 1ns/1ps
module tb_sram_emu;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
  localparam logic [31:0] BUS_Z = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] addr = '0;
  logic        CS = 1'b1;
  logic        OE = 1'b1;
  logic        WE = 1'b1;
  logic        busy;
  logic        viol;
  wire  [31:0] data;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_val = '0;

  assign data = tb_drv ? tb_val : 'z;
  pullup (data);

  sram_emu #(.ADDR_W(ADDR_W), .READ_LAT(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .data (data),
    .CS   (CS),
    .OE   (OE),
    .WE   (WE),
    .busy (busy),
    .viol (viol)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic        exp_busy;
    logic        exp_viol;
    logic [31:0] exp_bus;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [int];
  logic [19:0] known[$];
  bit          viol_model = 1'b0;

  function automatic bit out_of_range(input logic [19:0] a);
    return a[19:ADDR_W] != '0;
  endfunction

  function automatic logic [31:0] read_value(input logic [19:0] a);
    if (out_of_range(a)) return 32'h0000_0000;
    return ref_mem[int'(a)];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checkOutput({mon_e.tag, ".busy"}, {31'b0, busy}, {31'b0, mon_e.exp_busy});
      checkOutput({mon_e.tag, ".viol"}, {31'b0, viol}, {31'b0, mon_e.exp_viol});
      checkOutput({mon_e.tag, ".bus"}, data, mon_e.exp_bus);
    end
  end

  // One bus cycle: drive pins after the edge and queue what they should produce.
  task automatic applyStimulus(input bit rst_n, input bit cs_n, input bit oe_n, input bit we_n,
                               input logic [19:0] a, input bit drv, input logic [31:0] val,
                               input bit exp_busy, input bit exp_drive, input logic [31:0] exp_val,
                               input bit set_viol, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = rst_n;
    CS     = cs_n;
    OE     = oe_n;
    WE     = we_n;
    addr   = a;
    tb_drv = drv;
    tb_val = val;
    if (!rst_n) viol_model = 1'b0;
    e.exp_busy = rst_n ? exp_busy : 1'b0;
    e.exp_viol = viol_model;
    e.exp_bus  = drv ? val : (exp_drive ? exp_val : BUS_Z);
    e.tag      = tag;
    sb_q.push_back(e);
    if (rst_n) viol_model = viol_model | set_viol;
  endtask

  task automatic do_idle(input int n);
    repeat (n) applyStimulus(1, 1, 1, 1, 20'h0, 0, 32'h0, 0, 0, 32'h0, 0, "idle");
  endtask

  task automatic do_reset();
    applyStimulus(0, 1, 1, 1, 20'h0, 0, 32'h0, 0, 0, 32'h0, 0, "rst");
  endtask

  // Write held for w cycles; from cycle chg (if >0) the address moves to alt.
  task automatic do_write(input logic [19:0] a0, input int w, input bit oe_low, input int chg,
                          input logic [19:0] alt, input logic [31:0] v0, input logic [31:0] stp,
                          input bit end_with_reset);
    logic [19:0] a;
    logic [31:0] v;
    bit          sv;
    a = a0;
    v = v0;
    for (int c = 0; c < w; c++) begin
      a  = (chg > 0 && c >= chg) ? alt : a0;
      v  = v0 + 32'(c) * stp;
      sv = (c == 0) ? out_of_range(a0) : (a != a0);
      applyStimulus(1, 0, !oe_low, 0, a, 1, v, c > 0, 0, 32'h0, sv, "wr");
    end
    if (end_with_reset) begin
      do_reset();
    end else begin
      applyStimulus(1, 1, 1, 1, a, 0, 32'h0, 1, 0, 32'h0, 0, "wr_end");
      if (!out_of_range(a0)) begin
        if (!ref_mem.exists(int'(a0))) known.push_back(a0);
        ref_mem[int'(a0)] = v;
      end
    end
  endtask

  // Read held for h cycles. Data appears LAT+1 cycles after the cycle in which
  // the current address was first presented, and a new address restarts that count.
  task automatic do_read(input logic [19:0] a0, input int h, input int chg, input logic [19:0] alt);
    logic [19:0] a;
    logic [19:0] prev;
    logic [19:0] r_addr;
    int          r;
    bit          drive;
    bit          sv;
    r      = 0;
    r_addr = a0;
    prev   = a0;
    a      = a0;
    for (int c = 0; c < h; c++) begin
      a     = (chg > 0 && c >= chg) ? alt : a0;
      drive = (c >= r + LAT + 1);
      sv    = (c == 0) ? out_of_range(a0) : ((a != prev) && out_of_range(a));
      applyStimulus(1, 0, 0, 1, a, 0, 32'h0, c > 0, drive, read_value(r_addr), sv, "rd");
      if (c > 0 && a != prev) begin
        r      = c;
        r_addr = a;
      end
      prev = a;
    end
    applyStimulus(1, 1, 1, 1, a, 0, 32'h0, 1, 0, 32'h0, 0, "rd_end");
  endtask

  initial begin
    logic [19:0] a;
    logic [19:0] alt;
    int          w;
    int          h;
    int          chg;
    int          kind;

    do_reset();
    do_reset();
    do_idle(2);

    // Basic write then read back at the programmed latency.
    do_write(20'd5, 3, 0, 0, 20'd0, 32'hCAFE_0001, 32'h0, 0);
    do_idle(1);
    do_read(20'd5, 6, 0, 20'd0);
    do_idle(1);

    // OE low during a write must not turn the bus around; last sample wins.
    do_write(20'd6, 1, 0, 0, 20'd0, 32'h0000_ABCD, 32'h0, 0);
    do_idle(1);
    do_write(20'd9, 3, 1, 0, 20'd0, 32'h0000_0011, 32'h0000_0011, 0);
    do_idle(1);
    do_read(20'd9, 5, 0, 20'd0);
    do_idle(1);

    // Address switch while data is on the bus restarts the latency.
    do_read(20'd5, 10, 5, 20'd6);
    do_idle(1);

    // Reset in the middle of a write discards it.
    do_write(20'd7, 1, 0, 0, 20'd0, 32'h0000_0077, 32'h0, 0);
    do_idle(1);
    do_write(20'd7, 2, 0, 0, 20'd0, 32'hDEAD_BEEF, 32'h1, 1);
    do_idle(1);
    do_read(20'd7, 5, 0, 20'd0);
    do_idle(1);

    // Out-of-range write must not alias onto address 0; out-of-range read gives 0.
    do_write(20'd0, 1, 0, 0, 20'd0, 32'h0000_1234, 32'h0, 0);
    do_idle(1);
    do_write(20'h0_0800, 2, 0, 0, 20'd0, 32'h5A5A_5A5A, 32'h0, 0);
    do_idle(1);
    do_read(20'd0, 5, 0, 20'd0);
    do_idle(1);
    do_read(20'h0_0800, 5, 0, 20'd0);
    do_idle(1);

    // Address moving during a write: flagged, committed to the first address only.
    do_reset();
    do_idle(1);
    do_write(20'd11, 1, 0, 0, 20'd0, 32'h0000_5555, 32'h0, 0);
    do_idle(1);
    do_write(20'd10, 4, 0, 2, 20'd11, 32'h0000_1000, 32'h0000_0010, 0);
    do_idle(1);
    do_read(20'd10, 5, 0, 20'd0);
    do_idle(1);
    do_read(20'd11, 5, 0, 20'd0);
    do_idle(1);

    // Randomized mix of reads, writes, range errors and resets.
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        a   = 20'($urandom_range(0, 15));
        alt = 20'($urandom_range(0, 15));
        w   = $urandom_range(1, 4);
        chg = (w > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, w - 1) : 0;
        do_write(a, w, 1'($urandom_range(0, 1)), chg, alt, $urandom, 32'($urandom_range(0, 255)), 0);
      end else if (kind <= 7) begin
        a   = known[$urandom_range(0, known.size() - 1)];
        alt = known[$urandom_range(0, known.size() - 1)];
        h   = $urandom_range(1, 7);
        chg = (h > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, h - 1) : 0;
        do_read(a, h, chg, alt);
      end else if (kind == 8) begin
        a = {10'($urandom_range(1, 1023)), 10'($urandom_range(0, 1023))};
        if ($urandom_range(0, 1) == 1)
          do_write(a, $urandom_range(1, 3), 0, 0, 20'd0, $urandom, 32'h0, 0);
        else
          do_read(a, $urandom_range(1, 6), 0, 20'd0);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          do_reset();
        end else begin
          a = 20'($urandom_range(0, 15));
          do_write(a, $urandom_range(1, 3), 0, 0, 20'd0, $urandom, 32'h3, 1);
        end
      end
      do_idle($urandom_range(1, 2));
    end

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    n_bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
